// File: rtl/pipe_mux_if.sv
// pipe_mux_if -- handshake and data bundle for pipe_mux.
//
// Purpose: groups the NSRC:1 source mux inputs, the upstream valid/ready pair,
// the flush strobe, the downstream valid/ready pair with head data, and the
// sticky select-error flag.
//
// Signals:
//   src       flattened sources, source k at [k*WIDTH +: WIDTH]
//   sel       source select, sampled on accept
//   in_valid  upstream offers a transfer
//   in_ready  block can accept this cycle
//   flush     synchronous discard of all buffered entries
//   out       head entry data (0 when empty)
//   out_sel   select stored with the head entry (0 when empty)
//   out_valid head entry present
//   out_ready downstream consumes the head entry
//   err       sticky out-of-range select flag
//
// Modports: master = traffic source/sink around the block, slave = pipe_mux.
interface pipe_mux_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
);
    logic [NSRC*WIDTH-1:0] src;
    logic [SELW-1:0]       sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out;
    logic [SELW-1:0]       out_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic                  err;

    modport master (
        output src, sel, in_valid, flush, out_ready,
        input  in_ready, out, out_sel, out_valid, err
    );

    modport slave (
        input  src, sel, in_valid, flush, out_ready,
        output in_ready, out, out_sel, out_valid, err
    );
endinterface

// File: rtl/pipe_mux.sv
// pipe_mux -- NSRC:1 source mux feeding a 2-entry registered skid buffer.
//
// Purpose: on accept (in_valid && in_ready && !flush) the selected source slice
// (or zero when sel >= NSRC) is stored with its sel value. Entries leave in
// FIFO order on dequeue (out_valid && out_ready && !flush). in_ready depends
// only on registered occupancy, so there is no combinational path from
// in_valid or out_ready to in_ready. flush empties the buffer at the next edge.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; empties the buffer and clears err
//   bus    pipe_mux_if.slave (src, sel, in_valid, in_ready, flush,
//          out, out_sel, out_valid, out_ready, err)
//
// Configuration macro: PIPE_MUX_SEL_ERR_EN
//   defined   -> err is a sticky register set by any accept with sel >= NSRC,
//                cleared only by reset
//   undefined -> err is tied to 0 and no register is built
module pipe_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic        clk,
    input  logic        reset,
    pipe_mux_if.slave   bus
);

    // Selected source slice; selects past the last source read as zero.
    function automatic logic [WIDTH-1:0] mux_src(
        input logic [NSRC*WIDTH-1:0] s,
        input logic [SELW-1:0]       k
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (int'(k) == i) r = s[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    function automatic logic sel_out_of_range(input logic [SELW-1:0] k);
        return int'(k) >= NSRC;
    endfunction

    // Entry 0 (_p0) is always the head; entry 1 (_p1) is only valid when
    // entry 0 is, so occupancy = vld_p0 + vld_p1.
    logic [WIDTH-1:0] data_p0, data_p1;
    logic [SELW-1:0]  sel_p0,  sel_p1;
    logic             vld_p0,  vld_p1;

    logic [WIDTH-1:0] data_p0_n, data_p1_n;
    logic [SELW-1:0]  sel_p0_n,  sel_p1_n;
    logic             vld_p0_n,  vld_p1_n;

    logic             accept;
    logic             deq;
    logic [WIDTH-1:0] mux_data;

    assign mux_data = mux_src(bus.src, bus.sel);
    assign accept   = bus.in_valid && !vld_p1 && !bus.flush;
    assign deq      = vld_p0 && bus.out_ready && !bus.flush;

    // ---- Stage: mux -> skid buffer (next-state) ----
    always_comb begin
        data_p0_n = data_p0;
        data_p1_n = data_p1;
        sel_p0_n  = sel_p0;
        sel_p1_n  = sel_p1;
        vld_p0_n  = vld_p0;
        vld_p1_n  = vld_p1;

        // Dequeue shifts the second entry into the head slot.
        if (deq) begin
            data_p0_n = data_p1;
            sel_p0_n  = sel_p1;
            vld_p0_n  = vld_p1;
            vld_p1_n  = 1'b0;
        end

        // The new entry lands in the first free slot after any shift, which
        // keeps FIFO order and puts it at the head when occupancy was 1 and a
        // dequeue happened in the same cycle.
        if (accept) begin
            if (!vld_p0_n) begin
                data_p0_n = mux_data;
                sel_p0_n  = bus.sel;
                vld_p0_n  = 1'b1;
            end else begin
                data_p1_n = mux_data;
                sel_p1_n  = bus.sel;
                vld_p1_n  = 1'b1;
            end
        end

        // Flush overrides any simultaneous accept or dequeue.
        if (bus.flush) begin
            vld_p0_n = 1'b0;
            vld_p1_n = 1'b0;
        end
    end

    // ---- Stage: skid buffer registers ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            data_p0 <= '0;
            data_p1 <= '0;
            sel_p0  <= '0;
            sel_p1  <= '0;
        end else begin
            vld_p0  <= vld_p0_n;
            vld_p1  <= vld_p1_n;
            data_p0 <= data_p0_n;
            data_p1 <= data_p1_n;
            sel_p0  <= sel_p0_n;
            sel_p1  <= sel_p1_n;
        end
    end

    // ---- Stage: head outputs ----
    // Stale entry contents are masked so an empty buffer always presents zero.
    assign bus.in_ready  = !vld_p1;
    assign bus.out_valid = vld_p0;
    assign bus.out       = vld_p0 ? data_p0 : '0;
    assign bus.out_sel   = vld_p0 ? sel_p0  : '0;

`ifdef PIPE_MUX_SEL_ERR_EN
    logic err_q;

    // Sticky: flush does not clear it, only reset does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (accept && sel_out_of_range(bus.sel)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_mux.sv
// tb_pipe_mux -- scoreboard bench for pipe_mux (WIDTH=32, NSRC=3, SELW=2).
// The driver pushes {sel, expected data} whenever it issues an accepted
// transfer; an independent monitor pops and compares on every dequeue.
module tb_pipe_mux;
    localparam int WIDTH = 32;
    localparam int NSRC  = 3;
    localparam int SELW  = 2;

`ifdef PIPE_MUX_SEL_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk;
    logic reset;

    pipe_mux_if #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) ifc ();

    pipe_mux #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int dq_count = 0;

    logic [SELW+WIDTH-1:0] sb[$];
    logic [SELW+WIDTH-1:0] pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each dequeue must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [SELW+WIDTH-1:0] e;
        if (!reset && ifc.out_valid && ifc.out_ready && !ifc.flush) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_word", 64'(ifc.out), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("mon_data", 64'(ifc.out), 64'(e[WIDTH-1:0]));
                chk("mon_sel", 64'(ifc.out_sel), 64'(e[SELW+WIDTH-1:WIDTH]));
                dq_count++;
            end
        end
    end

    // Offer word d on source s; all other slices carry ~d so a wrong pick shows.
    task automatic set_in(input logic v, input logic [SELW-1:0] s,
                          input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e);
        logic [NSRC*WIDTH-1:0] f;
        f = {NSRC{~d}};
        if (int'(s) < NSRC) f[int'(s)*WIDTH +: WIDTH] = d;
        ifc.src      = f;
        ifc.sel      = s;
        ifc.in_valid = v;
        pend         = {s, e};
    endtask

    // Record what the coming edge does to the buffer, then advance one cycle.
    task automatic tick();
        if (ifc.flush) sb.delete();
        else if (ifc.in_valid && ifc.in_ready) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int dq0;
        reset         = 1'b1;
        ifc.flush     = 1'b0;
        ifc.out_ready = 1'b0;
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        #3;
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_out", 64'(ifc.out), 64'd0);
        chk("rst_out_sel", 64'(ifc.out_sel), 64'd0);
        chk("rst_err", 64'(ifc.err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single transfer, one-cycle latency.
        ifc.out_ready = 1'b1;
        set_in(1'b1, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("lat_out_valid", 64'(ifc.out_valid), 64'd1);
        chk("lat_out", 64'(ifc.out), 64'hDEAD_BEEF);
        chk("lat_out_sel", 64'(ifc.out_sel), 64'd2);
        tick();
        chk("lat_empty_valid", 64'(ifc.out_valid), 64'd0);
        chk("lat_empty_out", 64'(ifc.out), 64'd0);
        chk("lat_empty_sel", 64'(ifc.out_sel), 64'd0);

        // Fill to two entries while stalled, then drain.
        ifc.out_ready = 1'b0;
        set_in(1'b1, 2'd0, 32'd1, 32'd1);
        tick();
        chk("fill1_in_ready", 64'(ifc.in_ready), 64'd1);
        set_in(1'b1, 2'd1, 32'd2, 32'd2);
        tick();
        chk("fill2_in_ready", 64'(ifc.in_ready), 64'd0);
        chk("fill2_head", 64'(ifc.out), 64'd1);
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("stall_valid", 64'(ifc.out_valid), 64'd1);
        chk("stall_out", 64'(ifc.out), 64'd1);
        chk("stall_sel", 64'(ifc.out_sel), 64'd0);
        ifc.out_ready = 1'b1;
        tick();
        chk("drain_out2", 64'(ifc.out), 64'd2);
        chk("drain_in_ready", 64'(ifc.in_ready), 64'd1);
        tick();
        chk("drain_empty", 64'(ifc.out_valid), 64'd0);

        // Sustained stream: one transfer per cycle.
        dq0 = dq_count;
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, SELW'(i % 3), 32'(i), 32'(i));
            chk("stream_in_ready", 64'(ifc.in_ready), 64'd1);
            tick();
            chk("stream_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("stream_out", 64'(ifc.out), 64'(i));
        end
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        tick();
        chk("stream_done_valid", 64'(ifc.out_valid), 64'd0);
        chk("stream_dq_count", 64'(dq_count - dq0), 64'd16);

        // Flush at occupancy 2 with a simultaneous offer and consume.
        ifc.out_ready = 1'b0;
        set_in(1'b1, 2'd0, 32'hA, 32'hA);
        tick();
        set_in(1'b1, 2'd1, 32'hB, 32'hB);
        tick();
        chk("pre_flush_in_ready", 64'(ifc.in_ready), 64'd0);
        ifc.flush     = 1'b1;
        ifc.out_ready = 1'b1;
        set_in(1'b1, 2'd2, 32'hC, 32'hC);
        tick();
        ifc.flush = 1'b0;
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("flush_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("flush_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("flush_out", 64'(ifc.out), 64'd0);
        set_in(1'b1, 2'd1, 32'h5555_5555, 32'h5555_5555);
        tick();
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("post_flush_out", 64'(ifc.out), 64'h5555_5555);
        tick();
        chk("post_flush_empty", 64'(ifc.out_valid), 64'd0);

        // Out-of-range select: zero data, sticky err.
        chk("pre_oor_err", 64'(ifc.err), 64'd0);
        ifc.out_ready = 1'b0;
        set_in(1'b1, 2'd3, 32'h0, 32'h0);
        tick();
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("oor_out", 64'(ifc.out), 64'd0);
        chk("oor_out_sel", 64'(ifc.out_sel), 64'd3);
        chk("oor_valid", 64'(ifc.out_valid), 64'd1);
        chk("oor_err", 64'(ifc.err), 64'(EXP_ERR));
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        chk("oor_err_after_flush", 64'(ifc.err), 64'(EXP_ERR));
        chk("oor_flushed_valid", 64'(ifc.out_valid), 64'd0);

        // Asynchronous reset mid-cycle at occupancy 2.
        set_in(1'b1, 2'd0, 32'h11, 32'h11);
        tick();
        set_in(1'b1, 2'd2, 32'h22, 32'h22);
        tick();
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("pre_areset_in_ready", 64'(ifc.in_ready), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        chk("areset_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("areset_out", 64'(ifc.out), 64'd0);
        chk("areset_in_ready", 64'(ifc.in_ready), 64'd1);
        chk("areset_err", 64'(ifc.err), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifc.out_ready = 1'b1;
        set_in(1'b1, 2'd1, 32'h77, 32'h77);
        tick();
        set_in(1'b0, 2'd0, 32'h0, 32'h0);
        chk("after_reset_valid", 64'(ifc.out_valid), 64'd1);
        chk("after_reset_out", 64'(ifc.out), 64'h77);
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_mux.md
PIPE_MUX -- requirements
Module: pipe_mux

Interface
REQ-001 WIDTH, 32, data width of each source and of out; SHALL be 1..64.
REQ-002 NSRC, 4, number of sources; SHALL be 2..8; need not be a power of two.
REQ-003 SELW, 2, select width; SHALL satisfy 2**SELW >= NSRC.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 src  input  NSRC*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  input  SELW  source select, sampled on accept.
REQ-008 in_valid  input  1  upstream offers a transfer.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 flush  input  1  synchronous discard of all buffered entries.
REQ-011 out  output  WIDTH  head entry data.
REQ-012 out_sel  output  SELW  sel value stored with the head entry.
REQ-013 out_valid  output  1  head entry present.
REQ-014 out_ready  input  1  downstream consumes the head entry.
REQ-015 err  output  1  sticky out-of-range select flag (see Configuration).

Function
REQ-016 Block SHALL be a 2-entry registered skid buffer behind an NSRC:1 mux; entry = {data, sel}.
REQ-017 Accept SHALL occur on a rising edge where in_valid && in_ready && !flush.
REQ-018 Accepted data SHALL be src slice sel when sel < NSRC, else all zeros.
REQ-019 Dequeue SHALL occur on a rising edge where out_valid && out_ready && !flush.
REQ-020 in_ready SHALL be 1 iff occupancy < 2, derived only from registered state (no in_valid/out_ready combinational path).
REQ-021 out_valid SHALL be 1 iff occupancy >= 1; out/out_sel SHALL be 0 whenever out_valid = 0.
REQ-022 Latency SHALL be 1 cycle: an accept at edge N with occupancy 0 yields out_valid = 1 and out = accepted data after edge N.
REQ-023 Order SHALL be FIFO; occupancy 1 with simultaneous accept and dequeue SHALL stay 1 with the new entry at head.
REQ-024 Occupancy 2 with dequeue SHALL go to 1 with the second entry at head; no accept possible at occupancy 2.
REQ-025 Sustained in_valid and out_ready SHALL give one transfer per cycle.
REQ-026 flush SHALL set occupancy to 0 at the next edge, overriding any simultaneous accept or dequeue.
REQ-027 out_valid SHALL not drop while out_ready = 0 except by flush or reset; out/out_sel SHALL be stable while stalled.

Reset
REQ-028 reset SHALL asynchronously force occupancy 0, both entries 0, err 0; in_ready = 1, out_valid = 0, out = 0, out_sel = 0.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; first accept SHALL be possible on the first edge after reset deasserts.

Configuration
REQ-030 Macro PIPE_MUX_SEL_ERR_EN: when defined, err SHALL set on any accept with sel >= NSRC and SHALL clear only on reset (not on flush).
REQ-031 Without PIPE_MUX_SEL_ERR_EN, err SHALL be constant 0 and no err register SHALL be built; REQ-018 zero-fill still applies.

Verification
REQ-032 Reset, then sel=2, src slice 2=32'hDEAD_BEEF, in_valid=1 one cycle, out_ready=1 -> next cycle out=32'hDEAD_BEEF, out_sel=2, out_valid=1; following cycle out_valid=0, out=0.
REQ-033 out_ready=0, accept A=1 then B=2 -> in_ready=0 after 2nd edge; out_ready=1 -> out=1 then out=2, in_ready returns 1.
REQ-034 Stream 16 words 0..15 with in_valid=out_ready=1 -> 16 consecutive out_valid cycles, values 0..15 in order, in_ready never 0.
REQ-035 Occupancy 2, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no word lost or duplicated is reported.
REQ-036 NSRC=3, SELW=2, accept sel=3 -> out=0, out_sel=3; with PIPE_MUX_SEL_ERR_EN err=1 and stays 1 through flush until reset; without it err=0.
REQ-037 Assert reset asynchronously mid-cycle at occupancy 2 -> out_valid=0, out=0, in_ready=1 immediately, before next clk edge.
